// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// Purpose:
//   VGA timing generator. A clock divider turns the system clock into a pixel
//   strobe (PIXEL_TICK). On each strobe a horizontal counter advances. When the
//   horizontal counter wraps, the vertical counter advances. Sync and
//   visible-region flags are decoded from the next counter values and stored in
//   flops. As a result they change on the same edge as PIXEL_X/PIXEL_Y, and
//   every output comes straight from a register.
//
// Optional feature:
//   VGA_SYNC_FRAME_PULSE_EN - when defined, adds output FRAME_START. It is a
//   one-CLK pulse that coincides with the PIXEL_TICK of the last pixel of a
//   frame (X=H_TOT-1, Y=V_TOT-1). When the macro is undefined, the port and its
//   logic do not exist.
//
// Ports:
//   CLK          in   system clock, all state on rising edge
//   RESET_N      in   asynchronous active-low reset
//   HSYNC        out  horizontal sync, active low
//   VSYNC        out  vertical sync, active low
//   H_ON         out  horizontal position inside visible region
//   V_ON         out  vertical position inside visible region
//   PIXEL_X      out  horizontal count 0..H_TOT-1
//   PIXEL_Y      out  vertical count 0..V_TOT-1
//   PIXEL_TICK   out  one-CLK strobe, high in the last divider cycle of a pixel
//   FRAME_START  out  (VGA_SYNC_FRAME_PULSE_EN only) end-of-frame strobe
// -----------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SW    = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SW    = 2,
    parameter int V_BP    = 33
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       H_ON,
    output logic       V_ON,
    output logic [9:0] PIXEL_X,
    output logic [9:0] PIXEL_Y,
    output logic       PIXEL_TICK
`ifdef VGA_SYNC_FRAME_PULSE_EN
    ,
    output logic       FRAME_START
`endif
);

    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SW);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SW);

    logic [DIV_W-1:0] div_reg, div_next;
    logic [9:0]       x_reg, x_next;
    logic [9:0]       y_reg, y_next;
    logic             tick_reg, tick_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             h_on_reg, h_on_next;
    logic             v_on_reg, v_on_next;

    always_comb begin
        div_next  = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        // The strobe is registered. It is computed from the divider's next
        // value, so it is high exactly while div_reg == DIV_LAST.
        tick_next = (div_next == DIV_LAST);

        x_next = x_reg;
        y_next = y_reg;
        if (tick_reg) begin
            if (x_reg == H_LAST) begin
                x_next = '0;
                y_next = (y_reg == V_LAST) ? '0 : y_reg + 1'b1;
            end else begin
                x_next = x_reg + 1'b1;
            end
        end

        // Decoding from the next counter values keeps the flags aligned with
        // PIXEL_X/PIXEL_Y, and it does so without a combinational output path.
        h_on_next  = (x_next < H_VIS_C);
        v_on_next  = (y_next < V_VIS_C);
        hsync_next = !((x_next >= HS_START) && (x_next < HS_END));
        vsync_next = !((y_next >= VS_START) && (y_next < VS_END));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_reg   <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            tick_reg  <= 1'b0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
            h_on_reg  <= 1'b1;
            v_on_reg  <= 1'b1;
        end else begin
            div_reg   <= div_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            tick_reg  <= tick_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
            h_on_reg  <= h_on_next;
            v_on_reg  <= v_on_next;
        end
    end

    assign PIXEL_X    = x_reg;
    assign PIXEL_Y    = y_reg;
    assign PIXEL_TICK = tick_reg;
    assign HSYNC      = hsync_reg;
    assign VSYNC      = vsync_reg;
    assign H_ON       = h_on_reg;
    assign V_ON       = v_on_reg;

`ifdef VGA_SYNC_FRAME_PULSE_EN
    logic frame_reg, frame_next;

    // Ticks are never back to back (CLK_DIV >= 2). In the cycle where
    // tick_next is high, x_next/y_next therefore equal the pixel whose tick
    // is being announced.
    always_comb begin
        frame_next = tick_next && (x_next == H_LAST) && (y_next == V_LAST);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_reg <= 1'b0;
        end else begin
            frame_reg <= frame_next;
        end
    end

    assign FRAME_START = frame_reg;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Instance A uses the default 640x480 timing. It exercises reset, the first
// tick and one full line.
// Instance B uses a reduced geometry (CLK_DIV=2, 16x12 total) so that whole
// frames, frame wrap and a mid-frame reset fit in a short run. Both instances
// are also compared every cycle against a closed-form timing model derived
// from the clock count since reset release.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n;
    logic       hs_a, vs_a, hon_a, von_a, tick_a;
    logic [9:0] x_a, y_a;
    logic       hs_b, vs_b, hon_b, von_b, tick_b;
    logic [9:0] x_b, y_b;
`ifdef VGA_SYNC_FRAME_PULSE_EN
    logic       fs_a, fs_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut_a (
        .CLK(clk), .RESET_N(rst_a_n),
        .HSYNC(hs_a), .VSYNC(vs_a), .H_ON(hon_a), .V_ON(von_a),
        .PIXEL_X(x_a), .PIXEL_Y(y_a), .PIXEL_TICK(tick_a)
`ifdef VGA_SYNC_FRAME_PULSE_EN
        , .FRAME_START(fs_a)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(2),
        .H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(3),
        .V_VIS(6), .V_FP(2), .V_SW(2), .V_BP(2)
    ) dut_b (
        .CLK(clk), .RESET_N(rst_b_n),
        .HSYNC(hs_b), .VSYNC(vs_b), .H_ON(hon_b), .V_ON(von_b),
        .PIXEL_X(x_b), .PIXEL_Y(y_b), .PIXEL_TICK(tick_b)
`ifdef VGA_SYNC_FRAME_PULSE_EN
        , .FRAME_START(fs_b)
`endif
    );

    // Expected {X, Y, TICK, HSYNC, VSYNC, H_ON, V_ON} n clocks after release.
    function automatic logic [24:0] model(input int n, input int div,
                                          input int hv, input int hf, input int hs, input int hb,
                                          input int vv, input int vf, input int vs, input int vb);
        int htot, vtot, idx, x, y;
        logic t, hsy, vsy, ho, vo;
        htot = hv + hf + hs + hb;
        vtot = vv + vf + vs + vb;
        idx  = n / div;
        x    = idx % htot;
        y    = (idx / htot) % vtot;
        t    = ((n % div) == (div - 1));
        hsy  = !((x >= hv + hf) && (x < hv + hf + hs));
        vsy  = !((y >= vv + vf) && (y < vv + vf + vs));
        ho   = (x < hv);
        vo   = (y < vv);
        return {10'(x), 10'(y), t, hsy, vsy, ho, vo};
    endfunction

    function automatic logic [24:0] model_a(input int n);
        return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [24:0] model_b(input int n);
        return model(n, 2, 8, 2, 3, 3, 6, 2, 2, 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    localparam logic [24:0] RESET_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    int na, nb;
    int hs_low_a, tick_cnt_a, vs_low_b, von_cnt_b, fs_cnt_b;

    initial begin
        logic [24:0] va, vb;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        hs_low_a = 0; tick_cnt_a = 0; vs_low_b = 0; von_cnt_b = 0; fs_cnt_b = 0;

        // Assert reset before any clock edge: the values must appear immediately.
        #3;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        #1;
        chk("a_async_reset", {7'd0, x_a, y_a, tick_a, hs_a, vs_a, hon_a, von_a}, {7'd0, RESET_VEC});
        repeat (5) @(negedge clk);
        chk("a_reset_hold", {7'd0, x_a, y_a, tick_a, hs_a, vs_a, hon_a, von_a}, {7'd0, RESET_VEC});
        chk("b_reset_hold", {7'd0, x_b, y_b, tick_b, hs_b, vs_b, hon_b, von_b}, {7'd0, RESET_VEC});
`ifdef VGA_SYNC_FRAME_PULSE_EN
        chk("fs_reset", {30'd0, fs_a, fs_b}, 32'd0);
`endif

        // Release both between edges; n counts rising edges since release.
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        na = 0;
        nb = 0;
        while (na < 3210) begin
            @(negedge clk);
            na++;
            nb++;
            va = {x_a, y_a, tick_a, hs_a, vs_a, hon_a, von_a};
            vb = {x_b, y_b, tick_b, hs_b, vs_b, hon_b, von_b};
            chk($sformatf("a_model n=%0d", na), {7'd0, va}, {7'd0, model_a(na)});
            chk($sformatf("b_model n=%0d", nb), {7'd0, vb}, {7'd0, model_b(nb)});

            if (na <= 3200) begin
                if (!hs_a) hs_low_a++;
                if (tick_a) tick_cnt_a++;
            end
            if (nb <= 384) begin
                if (!vs_b) vs_low_b++;
                if (von_b) von_cnt_b++;
`ifdef VGA_SYNC_FRAME_PULSE_EN
                if (fs_b) fs_cnt_b++;
                if (nb == 383) chk("b_fs_at_last_pixel", {31'd0, fs_b}, 32'd1);
`endif
            end

            // Directed points on the default-timing instance.
            case (na)
                1:    chk("a_tick_cycle2", {31'd0, tick_a}, 32'd0);
                2:    chk("a_tick_cycle3", {31'd0, tick_a}, 32'd0);
                3:    begin
                          chk("a_first_tick_cycle4", {31'd0, tick_a}, 32'd1);
                          chk("a_x_during_first_tick", {22'd0, x_a}, 32'd0);
                      end
                4:    begin
                          chk("a_x_after_first_tick", {22'd0, x_a}, 32'd1);
                          chk("a_tick_drops", {31'd0, tick_a}, 32'd0);
                      end
                2559: chk("a_hon_x639", {31'd0, hon_a}, 32'd1);
                2560: begin
                          chk("a_x_640", {22'd0, x_a}, 32'd640);
                          chk("a_hon_x640", {31'd0, hon_a}, 32'd0);
                      end
                2623: chk("a_hsync_x655", {31'd0, hs_a}, 32'd1);
                2624: chk("a_hsync_x656", {31'd0, hs_a}, 32'd0);
                3007: chk("a_hsync_x751", {31'd0, hs_a}, 32'd0);
                3008: chk("a_hsync_x752", {31'd0, hs_a}, 32'd1);
                3199: chk("a_xy_799_0", {12'd0, x_a, y_a}, {12'd0, 10'd799, 10'd0});
                3200: chk("a_xy_wrap_0_1", {12'd0, x_a, y_a}, {12'd0, 10'd0, 10'd1});
                default: ;
            endcase

            // Directed points on the reduced-geometry instance.
            case (nb)
                191: chk("b_von_y5", {31'd0, von_b}, 32'd1);
                192: chk("b_von_y6", {22'd0, y_b, 9'd0, von_b}, {22'd6, 10'd0});
                255: chk("b_vsync_y7", {31'd0, vs_b}, 32'd1);
                256: chk("b_vsync_y8", {31'd0, vs_b}, 32'd0);
                319: chk("b_vsync_y9", {31'd0, vs_b}, 32'd0);
                320: chk("b_vsync_y10", {31'd0, vs_b}, 32'd1);
                383: chk("b_xy_15_11", {11'd0, x_b, y_b, tick_b}, {11'd0, 10'd15, 10'd11, 1'b1});
                384: chk("b_xy_frame_wrap", {12'd0, x_b, y_b}, 32'd0);
                default: ;
            endcase
        end

        chk("a_hsync_low_clks_per_line", hs_low_a, 384);
        chk("a_ticks_per_line", tick_cnt_a, 800);
        chk("b_vsync_low_clks_per_frame", vs_low_b, 64);
        chk("b_von_clks_per_frame", von_cnt_b, 192);
`ifdef VGA_SYNC_FRAME_PULSE_EN
        chk("b_fs_once_per_frame", fs_cnt_b, 1);
`endif

        // Instance B now sits at X=5, Y=4. Reset it between edges.
        chk("b_pre_reset_xy", {12'd0, x_b, y_b}, {12'd0, 10'd5, 10'd4});
        #1;
        rst_b_n = 1'b0;
        #1;
        chk("b_midframe_async_reset", {7'd0, x_b, y_b, tick_b, hs_b, vs_b, hon_b, von_b}, {7'd0, RESET_VEC});
        repeat (3) @(negedge clk);
        na += 3;
        chk("b_midframe_reset_hold", {7'd0, x_b, y_b, tick_b, hs_b, vs_b, hon_b, von_b}, {7'd0, RESET_VEC});
        chk("a_unaffected_by_b_reset", {7'd0, x_a, y_a, tick_a, hs_a, vs_a, hon_a, von_a}, {7'd0, model_a(na)});
        rst_b_n = 1'b1;
        nb = 0;
        repeat (40) begin
            @(negedge clk);
            nb++;
            na++;
            chk($sformatf("b_restart n=%0d", nb),
                {7'd0, x_b, y_b, tick_b, hs_b, vs_b, hon_b, von_b}, {7'd0, model_b(nb)});
            chk($sformatf("a_model n=%0d", na),
                {7'd0, x_a, y_a, tick_a, hs_a, vs_a, hon_a, von_a}, {7'd0, model_a(na)});
            if (nb == 1) chk("b_restart_first_tick", {31'd0, tick_b}, 32'd1);
            if (nb == 2) chk("b_restart_x1", {12'd0, x_b, y_b}, {12'd0, 10'd1, 10'd0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system clocks per pixel (2..16).
REQ-002 SHALL have parameters H_VIS 640, H_FP 16, H_SW 96, H_BP 48, meaning horizontal visible, front porch, sync width and back porch in pixels.
REQ-003 SHALL have parameters V_VIS 480, V_FP 10, V_SW 2, V_BP 33, meaning vertical visible, front porch, sync width and back porch in lines.
REQ-004 SHALL have port CLK, input, 1, single system clock (100 MHz); all state on rising edge.
REQ-005 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port HSYNC, output, 1, horizontal sync to the VGA connector, active low.
REQ-007 SHALL have port VSYNC, output, 1, vertical sync to the VGA connector, active low.
REQ-008 SHALL have port H_ON, output, 1, high while the horizontal position is in the visible region.
REQ-009 SHALL have port V_ON, output, 1, high while the vertical position is in the visible region.
REQ-010 SHALL have port PIXEL_X, output, 10, current horizontal count.
REQ-011 SHALL have port PIXEL_Y, output, 10, current vertical count.
REQ-012 SHALL have port PIXEL_TICK, output, 1, one-CLK strobe marking each pixel advance; drives the text-generator and colour-stage timing.

Function
REQ-013 SHALL hold a divider counter 0..CLK_DIV-1 that increments every CLK and wraps to 0; PIXEL_TICK=1 exactly in the cycle the divider equals CLK_DIV-1.
REQ-014 SHALL advance PIXEL_X by 1 on the CLK edge that ends a PIXEL_TICK cycle, wrapping from H_TOT-1 to 0, where H_TOT=H_VIS+H_FP+H_SW+H_BP (800).
REQ-015 SHALL advance PIXEL_Y by 1 only on the edge where PIXEL_X wraps, wrapping from V_TOT-1 to 0, where V_TOT=V_VIS+V_FP+V_SW+V_BP (525).
REQ-016 SHALL apply both wraps on the same edge when PIXEL_X=H_TOT-1 and PIXEL_Y=V_TOT-1, giving X=0,Y=0; PIXEL_X/PIXEL_Y SHALL never reach H_TOT/V_TOT.
REQ-017 SHALL drive H_ON=1 when PIXEL_X<H_VIS, else 0, and V_ON=1 when PIXEL_Y<V_VIS, else 0.
REQ-018 SHALL drive HSYNC=0 when H_VIS+H_FP <= PIXEL_X < H_VIS+H_FP+H_SW (656..751), else 1.
REQ-019 SHALL drive VSYNC=0 when V_VIS+V_FP <= PIXEL_Y < V_VIS+V_FP+V_SW (490..491), else 1.
REQ-020 SHALL decode HSYNC, VSYNC, H_ON and V_ON from the counter registers with zero cycles of latency relative to PIXEL_X/PIXEL_Y, from registered flops only, with no outputs from combinational loops.
REQ-021 SHALL hold all outputs constant between PIXEL_TICK edges (CLK_DIV-1 cycles).

Reset
REQ-022 SHALL, while RESET_N=0, force divider=0, PIXEL_X=0, PIXEL_Y=0, PIXEL_TICK=0, HSYNC=1, VSYNC=1, H_ON=1, V_ON=1, independent of CLK.
REQ-023 SHALL, on reset deassertion, produce the first PIXEL_TICK on the CLK_DIV-th rising edge; reset asserted mid-frame SHALL abandon the frame and restart at X=0,Y=0.

Configuration
REQ-024 SHALL, when macro VGA_SYNC_FRAME_PULSE_EN is defined, add output FRAME_START (1 bit) that is high for exactly one CLK, coincident with PIXEL_TICK, when PIXEL_X=H_TOT-1 and PIXEL_Y=V_TOT-1, and is 0 in reset.
REQ-025 SHALL, when VGA_SYNC_FRAME_PULSE_EN is undefined, omit FRAME_START and its logic, with all other behaviour identical.

Verification
REQ-026 SHALL cover reset: RESET_N=0 for 5 cycles -> X=0,Y=0,HSYNC=1,VSYNC=1,H_ON=1,V_ON=1,PIXEL_TICK=0; release -> PIXEL_TICK first high in cycle 4, X=1 after that edge.
REQ-027 SHALL cover the line: run 800 ticks -> H_ON falls at X=640, HSYNC low X=656..751 (96 ticks = 384 CLK), X wraps 799->0 and Y increments 0->1 on the same edge.
REQ-028 SHALL cover the frame: run 420000 ticks (1,680,000 CLK) -> V_ON falls at Y=480, VSYNC low Y=490..491 (1600 ticks), X=799,Y=524 wraps to X=0,Y=0.
REQ-029 SHALL cover mid-frame reset: assert RESET_N=0 asynchronously at X=300,Y=200 between clock edges -> outputs take reset values before the next edge; timing restarts per REQ-026.
REQ-030 SHALL cover the configuration: with VGA_SYNC_FRAME_PULSE_EN, FRAME_START is high exactly once per 1,680,000 CLK, at X=799,Y=524; without the macro, the build succeeds with no FRAME_START port.
